rotimm_encoder: RTL and testbench
=================================

ROTIMM_ENCODER -- requirements
Module: rotimm_encoder

Interface
REQ-001 Parameter FULLW, default 32, operand width; only 32 is supported.
REQ-002 Parameter IMMW, default 8, immediate field width.
REQ-003 Parameter ROTW, default 4, rotate field width; the rotate amount is 2*rot4.
REQ-004 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  request pulse; sampled only in IDLE.
REQ-007 value  input  FULLW  constant to encode; sampled with an accepted start.
REQ-008 allow_inv  input  1  permit the inverted (MVN-style) encoding; sampled with an accepted start.
REQ-009 busy  output  1  high whenever state != IDLE.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 found  output  1  an encoding exists.
REQ-012 inv  output  1  the encoding applies to ~value.
REQ-013 imm8  output  IMMW  immediate field.
REQ-014 rot4  output  ROTW  rotate field.

Function
REQ-015 Encoding rule: a match at r means ROR(zero-extended imm8, 2*r) == target, i.e. ROL(target, 2*r)[31:8] == 0 and imm8 = ROL(target, 2*r)[7:0].
REQ-016 FSM states: IDLE, SEARCH, DONE.
REQ-017 IDLE, start=1: latch value and allow_inv; set rot counter=0 and pass=PLAIN (target=value); go to SEARCH.
REQ-018 SEARCH: exactly one candidate r is tested per cycle, in ascending order 0..15; the first match wins, giving the smallest rot4.
REQ-019 SEARCH, match: register found=1, inv=pass, imm8 and rot4=r; go to DONE.
REQ-020 SEARCH, no match, r<15: increment r.
REQ-021 SEARCH, no match, r=15, pass=PLAIN, allow_inv=1: set pass=INV (target=~value) and r=0; stay in SEARCH.
REQ-022 SEARCH, no match, r=15, otherwise: register found=0, inv=0, imm8=0, rot4=0; go to DONE.
REQ-023 DONE: done=1 for exactly this cycle, then go to IDLE unconditionally.
REQ-024 Latency from the edge that samples start: done is high after edge k+1 for a plain match at r=k, and after edge 17+k for an inverted match at r=k.
REQ-025 Latency with no match: done is high after edge 16 when allow_inv=0, and after edge 32 when allow_inv=1.
REQ-026 start SHALL be ignored while busy=1, including in DONE; a start in the IDLE cycle that follows DONE SHALL be accepted.
REQ-027 found, inv, imm8 and rot4 SHALL change only on the edge entering DONE, and SHALL hold until the next result or reset.
REQ-028 value and allow_inv SHALL have no effect between accepted starts.
REQ-029 value=0 SHALL match at r=0 with imm8=0, found=1, inv=0.
REQ-030 The rot counter SHALL never wrap past 15 within a pass.

Reset
REQ-031 With rst=1 at an edge: state=IDLE, busy=0, done=0, found=0, inv=0, imm8=0, rot4=0, and the counter and pass are cleared.
REQ-032 Reset mid-SEARCH SHALL abort the search with no done pulse.
REQ-033 rst SHALL take priority over start in the same cycle.

Verification
REQ-034 value=0x000000FF, allow_inv=0 -> done after edge 1; found=1, inv=0, imm8=0xFF, rot4=0.
REQ-035 value=0xFF000000 -> done after edge 5; found=1, imm8=0xFF, rot4=4; busy high for 5 cycles.
REQ-036 value=0x00000102, allow_inv=0 -> done after edge 16, found=0.
REQ-037 value=0x00000102, allow_inv=1 -> done after edge 32, found=0.
REQ-038 value=0xFFFFFF00, allow_inv=1 -> done after edge 17; found=1, inv=1, imm8=0xFF, rot4=0.
REQ-039 value=0x00000102 with allow_inv=1, plus a second start and a changed value at edge 3 -> second start ignored; rst at edge 10 -> next cycle busy=0, done never asserted, outputs all zero.
REQ-040 Back-to-back: a start in the cycle after done, value=0x3FC -> done after edge 16; found=1, imm8=0xFF, rot4=15.

Source files
------------

// File: rtl/rotimm_encoder.sv
// rotimm_encoder
// Finds an 8-bit-immediate / even-rotate encoding for a 32-bit constant.
// One rotate candidate is tested per cycle, in ascending order, so the first
// hit is the smallest rot4. When the caller allows it, a second pass searches
// the same way for an encoding of ~value (MVN-style).
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | waiting for start; result registers hold the last result
// S_SEARCH | testing candidate rot_q of the current pass (plain or inverted)
// S_DONE   | result registered; done pulses for this single cycle
module rotimm_encoder #(
    parameter int FULLW = 32,
    parameter int IMMW  = 8,
    parameter int ROTW  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [FULLW-1:0] value,
    input  logic             allow_inv,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic             inv,
    output logic [IMMW-1:0]  imm8,
    output logic [ROTW-1:0]  rot4
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SEARCH = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    // Shift amounts are 2*r and FULLW-2*r; one extra bit covers FULLW itself.
    localparam int SW = ROTW + 2;
    localparam logic [ROTW-1:0] R_LAST = '1;
    localparam logic            PASS_PLAIN = 1'b0;
    localparam logic            PASS_INV   = 1'b1;

    logic [1:0]       state_q;
    logic [FULLW-1:0] value_q;
    logic             allow_q;
    logic [ROTW-1:0]  rot_q;
    logic             pass_q;

    logic [FULLW-1:0] target;
    logic [SW-1:0]    lshamt;
    logic [SW-1:0]    rshamt;
    logic [FULLW-1:0] rolled;
    logic             match;
    logic             last_try;

    // Candidate test: rotate the current target left by 2*r and require
    // everything above the immediate field to be zero.
    always_comb begin
        target = (pass_q == PASS_INV) ? ~value_q : value_q;
        lshamt = {1'b0, rot_q, 1'b0};
        rshamt = SW'(FULLW) - lshamt;
        // A right shift by the full width yields zero, so r=0 is a plain copy.
        rolled = (target << lshamt) | (target >> rshamt);
        match  = (rolled[FULLW-1:IMMW] == '0);
        last_try = (rot_q == R_LAST) && !((pass_q == PASS_PLAIN) && allow_q);
    end

    // Control FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:   if (start) state_q <= S_SEARCH;
                S_SEARCH: if (match || last_try) state_q <= S_DONE;
                S_DONE:   state_q <= S_IDLE;
                default:  state_q <= S_IDLE;
            endcase
        end
    end

    // Operand capture, rotate counter and pass selection.
    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
            allow_q <= 1'b0;
            rot_q   <= '0;
            pass_q  <= PASS_PLAIN;
        end else if (state_q == S_IDLE) begin
            if (start) begin
                value_q <= value;
                allow_q <= allow_inv;
                rot_q   <= '0;
                pass_q  <= PASS_PLAIN;
            end
        end else if (state_q == S_SEARCH && !match) begin
            if (rot_q != R_LAST) begin
                rot_q <= rot_q + 1'b1;
            end else if ((pass_q == PASS_PLAIN) && allow_q) begin
                rot_q  <= '0;
                pass_q <= PASS_INV;
            end
        end
    end

    // Result registers: written only on the edge that enters S_DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            found <= 1'b0;
            inv   <= 1'b0;
            imm8  <= '0;
            rot4  <= '0;
        end else if (state_q == S_SEARCH) begin
            if (match) begin
                found <= 1'b1;
                inv   <= pass_q;
                imm8  <= rolled[IMMW-1:0];
                rot4  <= rot_q;
            end else if (last_try) begin
                found <= 1'b0;
                inv   <= 1'b0;
                imm8  <= '0;
                rot4  <= '0;
            end
        end
    end

    // Status outputs decoded straight from the state register.
    always_comb begin
        busy = (state_q != S_IDLE);
        done = (state_q == S_DONE);
    end

endmodule

// File: tb/tb_rotimm_encoder.sv
// Directed bench for rotimm_encoder: latency, results, reset and start handling.
module tb_rotimm_encoder;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] value;
    logic        allow_inv;
    logic        busy;
    logic        done;
    logic        found;
    logic        inv;
    logic [7:0]  imm8;
    logic [3:0]  rot4;

    int checks = 0;
    int errors = 0;

    rotimm_encoder #(.FULLW(32), .IMMW(8), .ROTW(4)) dut (
        .clk(clk), .rst(rst), .start(start), .value(value), .allow_inv(allow_inv),
        .busy(busy), .done(done), .found(found), .inv(inv), .imm8(imm8), .rot4(rot4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive start for one edge (edge 0); scrambles value/allow_inv afterwards.
    task automatic launch(input logic [31:0] v, input logic a);
        start = 1'b1;
        value = v;
        allow_inv = a;
        @(posedge clk);
        #1;
        start = 1'b0;
        value = ~v;
        allow_inv = ~a;
    endtask

    // Counts edges after edge 0 until done; also counts busy-but-not-done cycles.
    task automatic wait_done(output int edges, output int busy_cycles);
        edges = -1;
        busy_cycles = busy ? 1 : 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                edges = i;
                break;
            end
            if (busy) busy_cycles++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        value = 32'h0000_00FF;
        allow_inv = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (found !== 1'b0) begin errors++; $display("FAIL reset_found got %b want 0", found); end
        checks++; if (inv !== 1'b0) begin errors++; $display("FAIL reset_inv got %b want 0", inv); end
        checks++; if (imm8 !== 8'h00) begin errors++; $display("FAIL reset_imm8 got %h want 00", imm8); end
        checks++; if (rot4 !== 4'h0) begin errors++; $display("FAIL reset_rot4 got %h want 0", rot4); end
        rst = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_over_start got busy=%b want 0", busy); end
    endtask

    task automatic test_plain_r0();
        int e, b;
        launch(32'h0000_00FF, 1'b0);
        wait_done(e, b);
        checks++; if (e != 1) begin errors++; $display("FAIL r0_latency got %0d want 1", e); end
        checks++; if ({found, inv, imm8, rot4} !== {1'b1, 1'b0, 8'hFF, 4'h0})
            begin errors++; $display("FAIL r0_result got f=%b i=%b imm=%h rot=%h want 1 0 ff 0", found, inv, imm8, rot4); end
        @(posedge clk); #1;
    endtask

    task automatic test_plain_r4();
        int e, b;
        launch(32'hFF00_0000, 1'b0);
        wait_done(e, b);
        checks++; if (e != 5) begin errors++; $display("FAIL r4_latency got %0d want 5", e); end
        checks++; if (b != 5) begin errors++; $display("FAIL r4_busy_cycles got %0d want 5", b); end
        checks++; if ({found, inv, imm8, rot4} !== {1'b1, 1'b0, 8'hFF, 4'h4})
            begin errors++; $display("FAIL r4_result got f=%b i=%b imm=%h rot=%h want 1 0 ff 4", found, inv, imm8, rot4); end
        @(posedge clk); #1;
    endtask

    task automatic test_zero();
        int e, b;
        launch(32'h0000_0000, 1'b1);
        wait_done(e, b);
        checks++; if (e != 1) begin errors++; $display("FAIL zero_latency got %0d want 1", e); end
        checks++; if ({found, inv, imm8, rot4} !== {1'b1, 1'b0, 8'h00, 4'h0})
            begin errors++; $display("FAIL zero_result got f=%b i=%b imm=%h rot=%h want 1 0 00 0", found, inv, imm8, rot4); end
        @(posedge clk); #1;
    endtask

    task automatic test_nomatch();
        int e, b;
        launch(32'h0000_0102, 1'b0);
        wait_done(e, b);
        checks++; if (e != 16) begin errors++; $display("FAIL nomatch_latency got %0d want 16", e); end
        checks++; if ({found, inv, imm8, rot4} !== 14'h0)
            begin errors++; $display("FAIL nomatch_result got f=%b i=%b imm=%h rot=%h want all 0", found, inv, imm8, rot4); end
        @(posedge clk); #1;
        launch(32'h0000_0102, 1'b1);
        wait_done(e, b);
        checks++; if (e != 32) begin errors++; $display("FAIL nomatch_inv_latency got %0d want 32", e); end
        checks++; if ({found, inv, imm8, rot4} !== 14'h0)
            begin errors++; $display("FAIL nomatch_inv_result got f=%b i=%b imm=%h rot=%h want all 0", found, inv, imm8, rot4); end
        @(posedge clk); #1;
    endtask

    task automatic test_inverted();
        int e, b;
        launch(32'hFFFF_FF00, 1'b0);
        wait_done(e, b);
        checks++; if (e != 16 || found !== 1'b0)
            begin errors++; $display("FAIL inv_disallowed got edges=%0d found=%b want 16 0", e, found); end
        @(posedge clk); #1;
        launch(32'hFFFF_FF00, 1'b1);
        wait_done(e, b);
        checks++; if (e != 17) begin errors++; $display("FAIL inv_latency got %0d want 17", e); end
        checks++; if ({found, inv, imm8, rot4} !== {1'b1, 1'b1, 8'hFF, 4'h0})
            begin errors++; $display("FAIL inv_result got f=%b i=%b imm=%h rot=%h want 1 1 ff 0", found, inv, imm8, rot4); end
        @(posedge clk); #1;
    endtask

    task automatic test_abort();
        int seen_done = 0;
        launch(32'h0000_0102, 1'b1);
        for (int i = 1; i <= 9; i++) begin
            if (i == 3) begin
                start = 1'b1;
                value = 32'h0000_00FF;
                allow_inv = 1'b0;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) seen_done++;
        end
        checks++; if (seen_done != 0 || busy !== 1'b1)
            begin errors++; $display("FAIL abort_ignore_start got done_count=%0d busy=%b want 0 1", seen_done, busy); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0)
            begin errors++; $display("FAIL abort_state got busy=%b done=%b want 0 0", busy, done); end
        checks++; if ({found, inv, imm8, rot4} !== 14'h0)
            begin errors++; $display("FAIL abort_outputs got f=%b i=%b imm=%h rot=%h want all 0", found, inv, imm8, rot4); end
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done) seen_done++;
        end
        checks++; if (seen_done != 0) begin errors++; $display("FAIL abort_no_done got %0d pulses want 0", seen_done); end
    endtask

    task automatic test_done_ignore();
        int e, b;
        launch(32'h0000_00FF, 1'b0);
        wait_done(e, b);
        start = 1'b1;
        value = 32'h0000_03FC;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL done_start_ignored got busy=%b want 0", busy); end
        @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0 || rot4 !== 4'h0)
            begin errors++; $display("FAIL done_start_idle got busy=%b rot=%h want 0 0", busy, rot4); end
    endtask

    task automatic test_back_to_back();
        int e, b, e2;
        launch(32'hFF00_0000, 1'b0);
        wait_done(e, b);
        @(posedge clk);
        #1;
        launch(32'h0000_03FC, 1'b0);
        e2 = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (i == 5) begin
                checks++; if ({found, imm8, rot4} !== {1'b1, 8'hFF, 4'h4})
                    begin errors++; $display("FAIL b2b_hold got f=%b imm=%h rot=%h want 1 ff 4", found, imm8, rot4); end
            end
            if (done) begin
                e2 = i;
                break;
            end
        end
        checks++; if (e2 != 16) begin errors++; $display("FAIL b2b_latency got %0d want 16", e2); end
        checks++; if ({found, inv, imm8, rot4} !== {1'b1, 1'b0, 8'hFF, 4'hF})
            begin errors++; $display("FAIL b2b_result got f=%b i=%b imm=%h rot=%h want 1 0 ff f", found, inv, imm8, rot4); end
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        value = '0;
        allow_inv = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_plain_r0();
        test_plain_r4();
        test_zero();
        test_nomatch();
        test_inverted();
        test_abort();
        test_done_ignore();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
